// File: rtl/hazard_ctrl.sv
// hazard_ctrl: central stall/flush controller for the 5-stage RV32I pipeline.
// Resolves load-use hazards, taken branches/jumps and data-memory wait states.
// A memory wait that outlasts P_TIMEOUT consecutive busy cycles raises a trap.
// The trap holds until software acknowledges it.
// Optional build macro: HAZARD_PERF_CNT_EN adds saturating stall/flush counters.
module hazard_ctrl #(
  parameter int P_TIMEOUT = 16,
  parameter int P_CNT_W   = 8
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_id_rs1_used,
  input  logic       i_id_rs2_used,
  input  logic [4:0] i_ex_rd,
  input  logic       i_ex_load,
  input  logic       i_ex_br_taken,
  input  logic       i_mem_req,
  input  logic       i_mem_ack,
  input  logic       i_trap_ack,
  output logic       o_pc_stall,
  output logic       o_if_id_stall,
  output logic       o_if_id_flush,
  output logic       o_id_ex_stall,
  output logic       o_id_ex_flush,
  output logic       o_ex_mem_stall,
  output logic       o_mem_wb_flush,
  output logic       o_trap
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] o_stall_cycles,
  output logic [31:0] o_flush_events
`endif
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_TRAP     = 2'd2
  } state_t;

  // One bit per pipeline control line, so a whole decision moves as one value.
  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_stall;
    logic id_ex_flush;
    logic ex_mem_stall;
    logic mem_wb_flush;
    logic trap;
  } ctrl_t;

  localparam logic [P_CNT_W-1:0] TIMEOUT_C = P_CNT_W'(P_TIMEOUT);
  localparam logic [P_CNT_W-1:0] CNT_ONE   = P_CNT_W'(1);

  state_t               state, state_nxt;
  logic [P_CNT_W-1:0]   cnt, cnt_nxt, cnt_inc;
  logic                 mem_busy, load_use, rs1_hit, rs2_hit;
  ctrl_t                ctrl, ctrl_o;

  // Hazard terms from the ID and EX stage operand fields.
  always_comb begin
    mem_busy = i_mem_req & ~i_mem_ack;
    rs1_hit  = i_id_rs1_used & (i_id_rs1 == i_ex_rd);
    rs2_hit  = i_id_rs2_used & (i_id_rs2 == i_ex_rd);
    // x0 is never really written, so a load to it creates no dependency.
    load_use = i_ex_load & (i_ex_rd != 5'd0) & (rs1_hit | rs2_hit);
    cnt_inc  = cnt + CNT_ONE;
  end

  // State and wait-counter register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= S_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state and pipeline controls; priority is trap > mem_busy > branch > load_use.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ctrl      = '0;
    case (state)
      S_TRAP: begin
        ctrl.pc_stall     = 1'b1;
        ctrl.if_id_stall  = 1'b1;
        ctrl.id_ex_stall  = 1'b1;
        ctrl.ex_mem_stall = 1'b1;
        ctrl.mem_wb_flush = 1'b1;
        ctrl.trap         = 1'b1;
        if (i_trap_ack) begin
          state_nxt = S_RUN;
          cnt_nxt   = '0;
        end
      end
      S_RUN, S_MEM_WAIT: begin
        if (mem_busy) begin
          // Freeze everything up to EX/MEM; bubble WB while the access is pending.
          // Branch and load-use wait here and are seen again once EX moves.
          ctrl.pc_stall     = 1'b1;
          ctrl.if_id_stall  = 1'b1;
          ctrl.id_ex_stall  = 1'b1;
          ctrl.ex_mem_stall = 1'b1;
          ctrl.mem_wb_flush = 1'b1;
          cnt_nxt           = cnt_inc;
          // cnt is 0 in S_RUN, so cnt_inc counts this busy cycle in either state.
          if (cnt_inc >= TIMEOUT_C) state_nxt = S_TRAP;
          else                      state_nxt = S_MEM_WAIT;
        end else begin
          // An ack, or a dropped request, ends the wait in this same cycle.
          state_nxt = S_RUN;
          cnt_nxt   = '0;
          if (i_ex_br_taken) begin
            // The redirect must load, so the PC keeps moving; kill the two younger slots.
            ctrl.if_id_flush = 1'b1;
            ctrl.id_ex_flush = 1'b1;
          end else if (load_use) begin
            // One bubble is enough: the load reaches MEM next cycle and forwards.
            ctrl.pc_stall    = 1'b1;
            ctrl.if_id_stall = 1'b1;
            ctrl.id_ex_flush = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = S_RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Controls are forced quiet while reset is held, whatever the inputs show.
  always_comb begin
    ctrl_o = i_reset_n ? ctrl : '0;
  end

  assign o_pc_stall     = ctrl_o.pc_stall;
  assign o_if_id_stall  = ctrl_o.if_id_stall;
  assign o_if_id_flush  = ctrl_o.if_id_flush;
  assign o_id_ex_stall  = ctrl_o.id_ex_stall;
  assign o_id_ex_flush  = ctrl_o.id_ex_flush;
  assign o_ex_mem_stall = ctrl_o.ex_mem_stall;
  assign o_mem_wb_flush = ctrl_o.mem_wb_flush;
  assign o_trap         = ctrl_o.trap;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_events;

  // Saturating counters: PC stall cycles and branch flush events.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (ctrl_o.pc_stall && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 32'd1;
      if (ctrl_o.if_id_flush && (flush_events != '1))
        flush_events <= flush_events + 32'd1;
    end
  end

  assign o_stall_cycles = stall_cycles;
  assign o_flush_events = flush_events;
`endif

endmodule
